// File: rtl/factorial_arbiter.sv
// factorial_arbiter: round-robin owner of a single factorial unit shared by NREQ requesters.
// Latency: accept in T, fu_go in T+1, WAIT from T+2, resp_valid one cycle after the completion edge.
// Backpressure: requesters hold req_valid_i and their operand until req_ready_o; only one job is in flight.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_valid_i/req_n_i            per-requester request and 4-bit operand (slice i = [4i+3:4i])
//   req_ready_o, resp_valid_o      one-hot accept / result pulses
//   resp_data_o/err_o/timeout_o    result (0 on error), error flag, watchdog-timeout flag
//   fu_go_o, fu_n_o                start pulse and latched operand to the factorial unit
//   fu_out_i, fu_done_i, fu_error_i  unit result and completion/error levels
//   busy_o, owner_o                non-IDLE indicator, current (or last) job owner
//
// Optional feature: define FACTORIAL_ARB_TIMEOUT_EN to enable the WAIT watchdog (limit TIMEOUT cycles).
module factorial_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [4*NREQ-1:0] req_n_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic              resp_err_o,
    output logic              resp_timeout_o,
    output logic              fu_go_o,
    output logic [3:0]        fu_n_o,
    input  logic [31:0]       fu_out_i,
    input  logic              fu_done_i,
    input  logic              fu_error_i,
    output logic              busy_o,
    output logic [1:0]        owner_o
);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_params
        $error("factorial_arbiter: NREQ must be 2..4 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  fu_n_q, fu_n_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        done_prev_q, error_prev_q;
    logic        done_rise, error_rise, wd_expired;
    logic        any_req;
    logic [1:0]  win;
    logic [2:0]  cand;

    // Unit flags are tracked every cycle, not just in WAIT, so a level still
    // held from the previous job is already "old" when the new job starts.
    assign done_rise  = fu_done_i  & ~done_prev_q;
    assign error_rise = fu_error_i & ~error_prev_q;

`ifdef FACTORIAL_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;

    // Counter equals the index of the current WAIT cycle; cleared everywhere else.
    assign wd_d       = (state_q == S_WAIT) ? wd_q + WDW'(1) : '0;
    assign wd_expired = (state_q == S_WAIT) && (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Round-robin search starting one past the last served requester.
    // last_q < NREQ and k <= NREQ, so a single conditional subtract wraps.
    always_comb begin
        win     = last_q;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
            if (!any_req && ((req_valid_i & (NREQ'(1) << cand)) != '0)) begin
                any_req = 1'b1;
                win     = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        fu_n_d       = fu_n_q;
        data_d       = data_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        req_ready_o  = '0;
        resp_valid_o = '0;
        fu_go_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready_o = NREQ'(1) << win;
                    fu_n_d      = 4'(req_n_i >> {win, 2'b00});
                    owner_d     = win;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fu_go_o = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Error edge wins over a simultaneous done edge.
                if (error_rise) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (done_rise) begin
                    data_d  = fu_out_i;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_o = NREQ'(1) << owner_q;
                last_d       = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Nothing leaves the block while reset is being applied.
        if (reset_i) begin
            req_ready_o  = '0;
            resp_valid_o = '0;
            fu_go_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_q       <= 2'(NREQ - 1);
            fu_n_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            done_prev_q  <= 1'b0;
            error_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            fu_n_q       <= fu_n_d;
            data_q       <= data_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            done_prev_q  <= fu_done_i;
            error_prev_q <= fu_error_i;
        end
    end

    assign resp_data_o    = data_q;
    assign resp_err_o     = err_q;
    assign resp_timeout_o = tmo_q;
    assign fu_n_o         = fu_n_q;
    assign busy_o         = (state_q != S_IDLE);
    assign owner_o        = owner_q;

endmodule

// File: tb/tb_factorial_arbiter.sv
// tb_factorial_arbiter: directed table, corner sequences and randomized traffic for factorial_arbiter.
// A behavioural factorial-unit stub answers each fu_go after a programmable latency and holds its flag.
// A scoreboard predicts grants, results and timing from the round-robin and factorial rules.
module tb_factorial_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_n;
    logic [NREQ-1:0]   req_ready, resp_valid;
    logic [31:0]       resp_data, fu_out;
    logic              resp_err, resp_timeout, fu_go, fu_done, fu_error, busy;
    logic [3:0]        fu_n;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    factorial_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_n_i(req_n), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
        .resp_timeout_o(resp_timeout), .fu_go_o(fu_go), .fu_n_o(fu_n),
        .fu_out_i(fu_out), .fu_done_i(fu_done), .fu_error_i(fu_error),
        .busy_o(busy), .owner_o(owner)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- factorial unit stub ----------------
    int         stub_lat    = 3;
    bit         stub_silent = 1'b0;
    int         stub_cnt;
    logic [3:0] stub_n;
    bit         stub_run;

    always @(posedge clk) begin
        if (reset) begin
            fu_done  <= 1'b0;
            fu_error <= 1'b0;
            fu_out   <= '0;
            stub_run <= 1'b0;
        end else if (fu_go) begin
            fu_done  <= 1'b0;
            fu_error <= 1'b0;
            stub_run <= !stub_silent;
            stub_cnt <= stub_lat;
            stub_n   <= fu_n;
        end else if (stub_run) begin
            if (stub_cnt <= 1) begin
                stub_run <= 1'b0;
                if (stub_n > 4'd12) fu_error <= 1'b1;
                else begin
                    fu_out  <= fact(int'(stub_n));
                    fu_done <= 1'b1;
                end
            end else stub_cnt <= stub_cnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int owner; logic [3:0] n; int acc_cyc; } job_t;
    job_t q[$];
    int   mdl_last      = NREQ - 1;
    int   last_rise_cyc = -10;
    logic prev_done     = 1'b0;
    logic prev_err      = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mdl_last  = NREQ - 1;
            prev_done = 1'b0;
            prev_err  = 1'b0;
            check("reset_no_resp", 32'(resp_valid), 32'd0);
        end else begin
            if ((fu_done && !prev_done) || (fu_error && !prev_err)) last_rise_cyc = cyc;
            prev_done = fu_done;
            prev_err  = fu_error;
            if (req_ready != '0) begin
                int exp_w;
                exp_w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (mdl_last + k) % NREQ;
                    if (exp_w < 0 && req_valid[j]) exp_w = j;
                end
                if (exp_w < 0) check("grant_without_request", 32'(req_ready), 32'd0);
                else begin
                    job_t jb;
                    check("grant", 32'(req_ready), 32'(1) << exp_w);
                    jb.owner   = exp_w;
                    jb.n       = req_n[4*exp_w +: 4];
                    jb.acc_cyc = cyc;
                    q.push_back(jb);
                end
            end
            if (fu_go) begin
                if (q.size() == 0) check("go_without_job", 32'd1, 32'd0);
                else begin
                    check("go_timing", 32'(cyc), 32'(q[$].acc_cyc + 1));
                    check("fu_n", 32'(fu_n), 32'(q[$].n));
                end
            end
            if (resp_valid != '0) begin
                if (q.size() == 0) check("resp_without_job", 32'(resp_valid), 32'd0);
                else begin
                    job_t jb;
                    jb = q.pop_front();
                    check("resp_owner", 32'(resp_valid), 32'(1) << jb.owner);
                    mdl_last = jb.owner;
                    if (stub_silent) begin
                        check("tmo_err", 32'(resp_err), 32'd1);
                        check("tmo_flag", 32'(resp_timeout), 32'd1);
                        check("tmo_data", resp_data, 32'd0);
                        check("tmo_timing", 32'(cyc - jb.acc_cyc), 32'(TIMEOUT + 2));
                    end else begin
                        check("resp_err", 32'(resp_err), {31'd0, jb.n > 4'd12});
                        check("resp_data", resp_data, (jb.n > 4'd12) ? 32'd0 : fact(int'(jb.n)));
                        check("resp_timeout", 32'(resp_timeout), 32'd0);
                        check("resp_timing", 32'(cyc), 32'(last_rise_cyc + 1));
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_job(input int idx, input logic [3:0] n, output logic [NREQ-1:0] rv,
                           output logic [31:0] d, output logic e, output logic t, output int gos);
        bit seen;
        rv = '0; d = '0; e = 1'b0; t = 1'b0; gos = 0; seen = 1'b0;
        @(posedge clk); #1;
        req_valid[idx] = 1'b1;
        req_n[4*idx +: 4] = n;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[idx]) seen = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        if (!seen) begin
            check("accept_wait_expired", 32'd0, 32'd1);
            return;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (fu_go) gos++;
            if (resp_valid != '0) begin
                rv = resp_valid; d = resp_data; e = resp_err; t = resp_timeout;
                break;
            end
        end
    endtask

    typedef struct { int idx; logic [3:0] n; logic [31:0] exp_data; logic exp_err; } vec_t;
    vec_t vecs[7];

    // ---------------- main ----------------
    initial begin
        logic [NREQ-1:0] rv, acc;
        logic [31:0]     d;
        logic            e, t;
        int              gos, ng, seen_resp;
        int              order[4];

        vecs[0] = '{0, 4'd5,  32'd120,        1'b0};
        vecs[1] = '{2, 4'd12, 32'h1C8CFC00,   1'b0};
        vecs[2] = '{2, 4'd0,  32'd1,          1'b0};
        vecs[3] = '{1, 4'd13, 32'd0,          1'b1};
        vecs[4] = '{3, 4'd1,  32'd1,          1'b0};
        vecs[5] = '{0, 4'd10, 32'd3628800,    1'b0};
        vecs[6] = '{1, 4'd15, 32'd0,          1'b1};

        reset = 1'b1; req_valid = '0; req_n = '0;
        repeat (3) @(posedge clk);
        req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        check("rst_fu_go", 32'(fu_go), 32'd0);
        check("rst_fu_n", 32'(fu_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b0;

        // Directed table of single jobs.
        stub_lat = 2;
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].idx, vecs[i].n, rv, d, e, t, gos);
            check("tbl_resp_valid", 32'(rv), 32'(1) << vecs[i].idx);
            check("tbl_resp_data", d, vecs[i].exp_data);
            check("tbl_resp_err", 32'(e), 32'(vecs[i].exp_err));
            check("tbl_resp_timeout", 32'(t), 32'd0);
            check("tbl_fu_go_count", 32'(gos), 32'd1);
        end

        // Round-robin order from reset: all four, then only 1 and 3.
        do_reset();
        @(posedge clk); #1;
        req_n = {4'd2, 4'd3, 4'd1, 4'd4};
        req_valid = '1;
        ng = 0;
        for (int c = 0; c < 400 && ng < 4; c++) begin
            @(negedge clk);
            acc = req_ready;
            if (acc != '0) begin order[ng] = oh2i(acc); ng++; end
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
        end
        check("rr4_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) check("rr4_order", 32'(order[k]), 32'(k));
        req_valid = 4'b1010;
        ng = 0;
        for (int c = 0; c < 400 && ng < 2; c++) begin
            @(negedge clk);
            acc = req_ready;
            if (acc != '0) begin order[ng] = oh2i(acc); ng++; end
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
        end
        check("rr2_count", 32'(ng), 32'd2);
        check("rr2_first", 32'(order[0]), 32'd1);
        check("rr2_second", 32'(order[1]), 32'd3);
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);

        // Reset while requester 1 waits on a slow unit.
        do_reset();
        stub_lat = 30;
        run_job(1, 4'd6, rv, d, e, t, gos); // completes normally first
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_n[7:4] = 4'd6;
        acc = '0;
        for (int c = 0; c < 20 && acc == '0; c++) begin @(negedge clk); acc = req_ready; end
        check("mid_accept", 32'(acc), 32'b0010);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_go_after", 32'(fu_go), 32'd0);
        seen_resp = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); if (resp_valid != '0) seen_resp++; end
        check("mid_no_resp", 32'(seen_resp), 32'd0);
        stub_lat = 2;
        @(posedge clk); #1 req_valid = 4'b0011;
        acc = '0;
        for (int c = 0; c < 20 && acc == '0; c++) begin @(negedge clk); acc = req_ready; end
        check("mid_next_grant", 32'(acc), 32'b0001);
        @(posedge clk); #1 req_valid = '0;
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);

`ifdef FACTORIAL_ARB_TIMEOUT_EN
        stub_silent = 1'b1;
        run_job(2, 4'd5, rv, d, e, t, gos);
        check("wd_resp_valid", 32'(rv), 32'b0100);
        check("wd_err", 32'(e), 32'd1);
        check("wd_timeout", 32'(t), 32'd1);
        check("wd_data", d, 32'd0);
        stub_silent = 1'b0;
`endif

        // Randomized traffic checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            if (c % 50 == 0) stub_lat = $urandom_range(1, 5);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_n[4*i +: 4] = 4'($urandom_range(0, 14));
                end else if (req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
            end
        end
        req_valid = '0;
        for (int c = 0; c < 200 && (busy || q.size() != 0); c++) @(negedge clk);
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/factorial_arbiter.md
# factorial_arbiter

Round-robin scheduler that shares one factorial unit (Go/N in, Out/Done/Error back) among up to four requesters. It accepts requests over a valid/ready handshake, issues one Go pulse per job, detects completion or error, and returns the 32-bit result to the owning requester. It sits between the requester ports and a single factorial datapath/control pair, and owns that unit exclusively.

## Interface
- NREQ, 4: number of requesters, legal 2..4.
- TIMEOUT, 64: watchdog limit in cycles while waiting on the unit (used only with the macro below).

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; must hold, with stable operand, until its req_ready.
- req_n  in  4*NREQ  operand N per requester; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot one-cycle accept pulse.
- resp_valid  out  NREQ  one-hot one-cycle result pulse to the owner.
- resp_data  out  32  result, valid with resp_valid; 0 on error.
- resp_err  out  1  result is an error, valid with resp_valid.
- resp_timeout  out  1  error was a watchdog timeout, valid with resp_valid.
- fu_go  out  1  one-cycle start pulse to the factorial unit.
- fu_n  out  4  latched operand to the unit.
- fu_out  in  32  unit result.
- fu_done  in  1  unit completion flag.
- fu_error  in  1  unit error flag (operand overflow).
- busy  out  1  high in any state other than IDLE.
- owner  out  2  index of current job owner; last owner when idle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick winner by round-robin starting at last_grant+1 (mod NREQ); pulse req_ready[winner], latch req_n slice into fu_n, set owner; go to ISSUE. No request: stay.
- ISSUE: fu_go=1 for this cycle only; clear watchdog; go to WAIT.
- WAIT: register done_q/err_q each cycle. Completion = rising edge of fu_done or fu_error relative to previous cycle. Error edge takes priority if both rise together: resp_err=1, resp_data=0. Done only: resp_data=fu_out captured that edge. Go to RESP.
- RESP: resp_valid[owner]=1 one cycle with captured data/err; last_grant<=owner; go to IDLE.
- req_valid dropped before accept: simply not granted, no error.
- Requester re-asserting during its own RESP is arbitrated on the next IDLE cycle, behind others per pointer.
- Level-held fu_done/fu_error from a prior job do not complete a new job; only a fresh rising edge after ISSUE counts.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, resp_timeout=0, fu_go=0, fu_n=0, busy=0, owner=0, last_grant=NREQ-1 (requester 0 first), state IDLE.
- Accept in cycle T; fu_go in T+1; WAIT from T+2.
- Completion edge sampled at edge E; resp_valid high in the cycle after E.
- Minimum back-to-back spacing between accepts: 4 cycles plus unit latency.
- Reset in any state: job dropped, no resp_valid emitted, fu_go low from next cycle; unit shares reset.

## Configuration
- FACTORIAL_ARB_TIMEOUT_EN defined: watchdog counts WAIT cycles; on reaching TIMEOUT without completion, go to RESP with resp_err=1, resp_timeout=1, resp_data=0.
- Undefined: WAIT has no limit; resp_timeout tied 0; TIMEOUT ignored.

## Test plan
- Single request, requester 0, N=5 -> one req_ready, one fu_go, resp_valid[0] with resp_data=120, resp_err=0.
- N=12 then N=0 from requester 2 -> resp_data=0x1C8CFC00 then 1.
- N=13 (unit raises fu_error) -> resp_err=1, resp_data=0, resp_timeout=0.
- All four requesting from reset -> grants in order 0,1,2,3; then only 1 and 3 requesting -> order 1,3.
- Reset asserted mid-WAIT for requester 1 -> no resp_valid, busy=0 next cycle, next grant starts at requester 0.
- Macro defined, TIMEOUT=64, stub unit never raises done/error -> resp_valid with resp_err=1, resp_timeout=1 exactly 64 WAIT cycles after entry.
